// File: rtl/pwm_pkg.sv
// Shared PWM definitions: decoder state encoding and default timing constants,
// common to the generator and decoder sides.
package pwm_pkg;

  localparam int unsigned PWM_INTERVAL_DEFAULT = 1200;
  localparam int unsigned PWM_TIMEOUT_DEFAULT  = 2400;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    HIGH,
    LOW
  } pwm_dec_state_t;

endpackage

// File: rtl/pwm_decoder_if.sv
// PWM capture bus: sampled PWM line in, measured duty/period and status out.
interface pwm_decoder_if
  import pwm_pkg::*;
#(
  parameter int unsigned DW = $clog2(PWM_INTERVAL_DEFAULT),
  parameter int unsigned PW = $clog2(PWM_TIMEOUT_DEFAULT + 1)
);

  logic          pwm_in;
  logic [DW-1:0] duty_value;
  logic [PW-1:0] period_value;
  logic          valid;
  logic          stuck_high;
  logic          stuck_low;

  modport master (
    output pwm_in,
    input  duty_value, period_value, valid, stuck_high, stuck_low
  );

  modport slave (
    input  pwm_in,
    output duty_value, period_value, valid, stuck_high, stuck_low
  );

endinterface

// File: rtl/pwm_sync_filter.sv
// 2-FF synchronizer, optional glitch filter (PWM_DECODER_GLITCH_FILTER_EN) and registered
// edge detect. `level` is the filtered level aligned with the rise/fall strobes.
module pwm_sync_filter #(
  parameter int unsigned GLITCH_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q;
  logic       f;
  logic       f_d_q;
  logic       rise_q;
  logic       fall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], pwm_in};
    end
  end

`ifdef PWM_DECODER_GLITCH_FILTER_EN
  localparam int unsigned CW = $clog2(GLITCH_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic          filt_q;

  // Follow the synchronized line only after GLITCH_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else if (sync_q[1] == filt_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CW'(GLITCH_CYCLES - 1)) begin
      cnt_q  <= '0;
      filt_q <= sync_q[1];
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign f = filt_q;
`else
  assign f = sync_q[1];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_d_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      f_d_q  <= f;
      rise_q <= f & ~f_d_q;
      fall_q <= ~f & f_d_q;
    end
  end

  assign level = f_d_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/pwm_decoder.sv
// PWM capture: measures high time and rise-to-rise period, flags stuck-high/low lines.
// Optional input glitch filter enabled by defining PWM_DECODER_GLITCH_FILTER_EN.
module pwm_decoder
  import pwm_pkg::*;
#(
  parameter int unsigned PWM_INTERVAL  = PWM_INTERVAL_DEFAULT,
  parameter int unsigned TIMEOUT       = PWM_TIMEOUT_DEFAULT,
  parameter int unsigned GLITCH_CYCLES = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  pwm_decoder_if.slave  bus
);

  localparam int unsigned DW = $clog2(PWM_INTERVAL);
  localparam int unsigned PW = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] HiMax  = DW'(PWM_INTERVAL - 1);
  localparam logic [PW-1:0] PerMax = PW'(TIMEOUT);

  logic level, rise, fall, timeout;

  pwm_dec_state_t state_q, state_d;
  logic [DW-1:0]  hi_cnt_q, hi_cnt_d, duty_q, duty_d;
  logic [PW-1:0]  per_cnt_q, per_cnt_d, idle_cnt_q, idle_cnt_d, period_q, period_d;
  logic           valid_q, valid_d, stuck_high_q, stuck_high_d, stuck_low_q, stuck_low_d;

  pwm_sync_filter #(
    .GLITCH_CYCLES (GLITCH_CYCLES)
  ) u_sync_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .pwm_in (bus.pwm_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  // Expiry fires only on the step into TIMEOUT, so once per stuck episode; an edge wins.
  assign timeout = ~(rise | fall) && (idle_cnt_q == PerMax - PW'(1));

  always_comb begin
    state_d      = state_q;
    hi_cnt_d     = hi_cnt_q;
    per_cnt_d    = per_cnt_q;
    duty_d       = duty_q;
    period_d     = period_q;
    valid_d      = 1'b0;
    stuck_high_d = stuck_high_q;
    stuck_low_d  = stuck_low_q;

    if (rise || fall) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != PerMax) begin
      idle_cnt_d = idle_cnt_q + PW'(1);
    end else begin
      idle_cnt_d = idle_cnt_q;
    end

    if (fall) stuck_high_d = 1'b0;
    if (rise) stuck_low_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fall) state_d = ARM;
      end
      ARM: begin
        if (rise) begin
          state_d   = HIGH;
          hi_cnt_d  = DW'(1);
          per_cnt_d = PW'(1);
        end
      end
      HIGH: begin
        per_cnt_d = (per_cnt_q == PerMax) ? per_cnt_q : per_cnt_q + PW'(1);
        if (fall) begin
          state_d = LOW;
        end else begin
          hi_cnt_d = (hi_cnt_q == HiMax) ? hi_cnt_q : hi_cnt_q + DW'(1);
        end
      end
      LOW: begin
        if (rise) begin
          duty_d       = hi_cnt_q;
          period_d     = per_cnt_q;
          valid_d      = 1'b1;
          stuck_high_d = 1'b0;
          stuck_low_d  = 1'b0;
          hi_cnt_d     = DW'(1);
          per_cnt_d    = PW'(1);
          state_d      = HIGH;
        end else begin
          per_cnt_d = (per_cnt_q == PerMax) ? per_cnt_q : per_cnt_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      valid_d  = 1'b1;
      period_d = '0;
      if (level) begin
        stuck_high_d = 1'b1;
        stuck_low_d  = 1'b0;
        duty_d       = HiMax;
        state_d      = IDLE;
      end else begin
        stuck_low_d  = 1'b1;
        stuck_high_d = 1'b0;
        duty_d       = '0;
        state_d      = ARM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hi_cnt_q     <= '0;
      per_cnt_q    <= '0;
      idle_cnt_q   <= '0;
      duty_q       <= '0;
      period_q     <= '0;
      valid_q      <= 1'b0;
      stuck_high_q <= 1'b0;
      stuck_low_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_cnt_q     <= hi_cnt_d;
      per_cnt_q    <= per_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      duty_q       <= duty_d;
      period_q     <= period_d;
      valid_q      <= valid_d;
      stuck_high_q <= stuck_high_d;
      stuck_low_q  <= stuck_low_d;
    end
  end

  assign bus.duty_value   = duty_q;
  assign bus.period_value = period_q;
  assign bus.valid        = valid_q;
  assign bus.stuck_high   = stuck_high_q;
  assign bus.stuck_low    = stuck_low_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed bench for pwm_decoder: periodic capture, latency, stuck detection, saturation,
// mid-period reset and glitch handling (both filter builds).
module tb_pwm_decoder;
  import pwm_pkg::*;

  localparam int unsigned DW = $clog2(1200);
  localparam int unsigned PW = $clog2(2400 + 1);
`ifdef PWM_DECODER_GLITCH_FILTER_EN
  localparam int Lat = 4 + 3;
`else
  localparam int Lat = 4;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_decoder_if #(.DW(DW), .PW(PW)) bus ();

  pwm_decoder #(
    .PWM_INTERVAL  (1200),
    .TIMEOUT       (2400),
    .GLITCH_CYCLES (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Record every valid strobe, sampled on the falling edge.
  int   v_duty[$];
  int   v_period[$];
  int   v_cyc[$];
  logic v_sh[$];
  logic v_sl[$];
  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      v_duty.push_back(int'(bus.duty_value));
      v_period.push_back(int'(bus.period_value));
      v_cyc.push_back(cyc);
      v_sh.push_back(bus.stuck_high);
      v_sl.push_back(bus.stuck_low);
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run(input logic lvl, input int n);
    bus.pwm_in = lvl;
    repeat (n) tick();
  endtask

  task automatic clear_log();
    v_duty.delete();
    v_period.delete();
    v_cyc.delete();
    v_sh.delete();
    v_sl.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    clear_log();
  endtask

  task automatic test_reset();
    bus.pwm_in = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    tests++; if (bus.duty_value !== '0) begin fails++;
      $display("FAIL reset_duty: got %0d want 0", bus.duty_value); end
    tests++; if (bus.period_value !== '0) begin fails++;
      $display("FAIL reset_period: got %0d want 0", bus.period_value); end
    tests++; if (bus.valid !== 1'b0) begin fails++;
      $display("FAIL reset_valid: got %b want 0", bus.valid); end
    tests++; if ({bus.stuck_high, bus.stuck_low} !== 2'b00) begin fails++;
      $display("FAIL reset_stuck: got %b%b want 00", bus.stuck_high, bus.stuck_low); end
    rst_n = 1'b1;
    clear_log();
  endtask

  task automatic test_periodic();
    int c0;
    do_reset();
    run(1'b1, 300);
    run(1'b0, 900);
    repeat (3) begin
      run(1'b1, 300);
      run(1'b0, 900);
    end
    c0 = cyc;
    run(1'b1, 20);
    tests++; if (v_duty.size() != 3) begin fails++;
      $display("FAIL periodic_count: got %0d want 3", v_duty.size()); end
    if (v_duty.size() > 0) begin
      tests++; if (v_duty[0] != 300 || v_period[0] != 1200) begin fails++;
        $display("FAIL periodic_first: got %0d/%0d want 300/1200", v_duty[0], v_period[0]); end
      tests++; if (v_duty[$] != 300 || v_period[$] != 1200) begin fails++;
        $display("FAIL periodic_last: got %0d/%0d want 300/1200", v_duty[$], v_period[$]); end
      tests++; if (v_cyc[$] - c0 != Lat) begin fails++;
        $display("FAIL periodic_latency: got %0d want %0d", v_cyc[$] - c0, Lat); end
      tests++; if ({v_sh[$], v_sl[$]} !== 2'b00) begin fails++;
        $display("FAIL periodic_stuck: got %b%b want 00", v_sh[$], v_sl[$]); end
    end
  endtask

  // Continues from test_periodic, which leaves the line in a high phase.
  task automatic test_reset_mid();
    run(1'b1, 100);
    rst_n = 1'b0;
    tick();
    tests++; if (bus.duty_value !== '0 || bus.period_value !== '0 || bus.valid !== 1'b0)
    begin fails++;
      $display("FAIL midreset_out: got %0d/%0d/%b want 0/0/0",
               bus.duty_value, bus.period_value, bus.valid); end
    rst_n = 1'b1;
    clear_log();
    run(1'b1, 180);
    run(1'b0, 900);
    run(1'b1, 300);
    run(1'b0, 900);
    tests++; if (v_duty.size() != 0) begin fails++;
      $display("FAIL midreset_early: got %0d valids want 0", v_duty.size()); end
    run(1'b1, 20);
    tests++; if (v_duty.size() != 1) begin fails++;
      $display("FAIL midreset_count: got %0d want 1", v_duty.size()); end
    else if (v_duty[0] != 300 || v_period[0] != 1200) begin
      tests++; fails++;
      $display("FAIL midreset_value: got %0d/%0d want 300/1200", v_duty[0], v_period[0]);
    end else tests++;
  endtask

  task automatic test_stuck_low();
    int c0;
    int n;
    bus.pwm_in = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    clear_log();
    c0 = cyc;
    n = 0;
    while (v_duty.size() == 0 && n < 3000) begin
      tick();
      n++;
    end
    tests++; if (v_duty.size() == 0) begin fails++;
      $display("FAIL stuck_low_seen: got no valid want valid within 3000 cycles"); end
    else begin
      tests++; if (v_cyc[0] - c0 != 2400) begin fails++;
        $display("FAIL stuck_low_time: got %0d want 2400", v_cyc[0] - c0); end
      tests++; if ({v_sh[0], v_sl[0]} !== 2'b01 || v_duty[0] != 0 || v_period[0] != 0)
      begin fails++;
        $display("FAIL stuck_low_value: got sh%b sl%b %0d/%0d want sh0 sl1 0/0",
                 v_sh[0], v_sl[0], v_duty[0], v_period[0]); end
    end
    run(1'b0, 2600);
    tests++; if (v_duty.size() != 1 || bus.stuck_low !== 1'b1) begin fails++;
      $display("FAIL stuck_low_once: got %0d valids sl%b want 1 valid sl1",
               v_duty.size(), bus.stuck_low); end
    run(1'b1, 600);
    tests++; if (bus.stuck_low !== 1'b0) begin fails++;
      $display("FAIL stuck_low_clear: got %b want 0", bus.stuck_low); end
    run(1'b0, 600);
    run(1'b1, 20);
    tests++; if (v_duty.size() != 2 || v_duty[$] != 600 || v_period[$] != 1200) begin fails++;
      $display("FAIL stuck_low_recover: got %0d valids last %0d/%0d want 2 valids 600/1200",
               v_duty.size(), v_duty[$], v_period[$]); end
  endtask

  // Continues from test_stuck_low, which leaves the line high.
  task automatic test_stuck_high();
    int n0;
    int n;
    n0 = v_duty.size();
    n = 0;
    bus.pwm_in = 1'b1;
    while (v_duty.size() == n0 && n < 3000) begin
      tick();
      n++;
    end
    tests++; if (v_duty.size() == n0) begin fails++;
      $display("FAIL stuck_high_seen: got no valid want valid within 3000 cycles"); end
    else begin
      tests++; if ({v_sh[$], v_sl[$]} !== 2'b10 || v_duty[$] != 1199 || v_period[$] != 0)
      begin fails++;
        $display("FAIL stuck_high_value: got sh%b sl%b %0d/%0d want sh1 sl0 1199/0",
                 v_sh[$], v_sl[$], v_duty[$], v_period[$]); end
    end
    run(1'b0, 20);
    tests++; if (bus.stuck_high !== 1'b0 || bus.duty_value !== DW'(1199)) begin fails++;
      $display("FAIL stuck_high_clear: got sh%b duty %0d want sh0 duty 1199",
               bus.stuck_high, bus.duty_value); end
  endtask

  task automatic test_saturate();
    do_reset();
    run(1'b1, 100);
    run(1'b0, 100);
    repeat (2) begin
      run(1'b1, 1500);
      run(1'b0, 500);
    end
    run(1'b1, 20);
    tests++; if (v_duty.size() != 2) begin fails++;
      $display("FAIL sat_count: got %0d want 2", v_duty.size()); end
    else begin
      tests++; if (v_duty[$] != 1199 || v_period[$] != 2000 || {v_sh[$], v_sl[$]} !== 2'b00)
      begin fails++;
        $display("FAIL sat_value: got %0d/%0d sh%b sl%b want 1199/2000 sh0 sl0",
                 v_duty[$], v_period[$], v_sh[$], v_sl[$]); end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    run(1'b1, 300);
    run(1'b0, 900);
    run(1'b1, 300);
    run(1'b0, 900);
    run(1'b1, 100);
    run(1'b0, 1);
    run(1'b1, 199);
    run(1'b0, 900);
    run(1'b1, 20);
`ifdef PWM_DECODER_GLITCH_FILTER_EN
    tests++; if (v_duty.size() != 2) begin fails++;
      $display("FAIL glitch_count: got %0d want 2", v_duty.size()); end
    else begin
      tests++; if (v_duty[1] != 300 || v_period[1] != 1200) begin fails++;
        $display("FAIL glitch_filtered: got %0d/%0d want 300/1200", v_duty[1], v_period[1]); end
    end
`else
    tests++; if (v_duty.size() != 3) begin fails++;
      $display("FAIL glitch_count: got %0d want 3", v_duty.size()); end
    else begin
      tests++; if (v_duty[1] != 100 || v_period[1] != 101) begin fails++;
        $display("FAIL glitch_split1: got %0d/%0d want 100/101", v_duty[1], v_period[1]); end
      tests++; if (v_duty[2] != 199 || v_period[2] != 1099) begin fails++;
        $display("FAIL glitch_split2: got %0d/%0d want 199/1099", v_duty[2], v_period[2]); end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_reset_mid();
    test_stuck_low();
    test_stuck_high();
    test_saturate();
    test_glitch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
